clkout_dly_ctrl: RTL

Sequencer for a forwarded-clock output path: an ODDR clock-forwarding flop followed by an IODELAY in VARIABLE mode. It accepts a requested output-delay tap, gates the forwarded clock low, steps the IODELAY one tap at a time with settle gaps, then re-enables the clock. This gives board bring-up runtime phase trimming of the output clock instead of a rebuild per delay value. It sits beside the clock-output pad logic in the `clk` domain that drives the ODDR/IODELAY.

---
 rtl/clkout_dly_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/clkout_dly_ctrl.sv
// Forwarded-clock output delay sequencer: gates the ODDR clock, walks the
// IODELAY tap one step at a time with settle gaps, then re-enables the clock.
// Ports: clk, reset_n (async, active-low); req/target in; ack/clamped done;
// busy, cur_tap status; clk_en -> ODDR D1; dly_rst/dly_ce/dly_inc -> IODELAY.
module clkout_dly_ctrl #(
  parameter int TAP_W    = 6,
  parameter int MAX_TAP  = 63,
  parameter int GATE_CYC = 4,
  parameter int SETTLE   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [TAP_W-1:0] target,
  output logic             ack,
  output logic             clamped,
  output logic             busy,
  output logic [TAP_W-1:0] cur_tap,
  output logic             clk_en,
  output logic             dly_rst,
  output logic             dly_ce,
  output logic             dly_inc
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_GATE_OFF,
    S_STEP,
    S_SETTLE,
    S_GATE_ON,
    S_DONE
  } state_e;

  localparam int CNT_W = 16;
  localparam logic [TAP_W-1:0] MAX_T =
    TAP_W'(MAX_TAP);
  localparam logic [CNT_W-1:0] GATE_LD =
    CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] SETL_LD =
    CNT_W'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAP_W-1:0] tgt_q, tgt_d;
  logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
  logic [TAP_W-1:0] req_tgt;
  logic ack_q, ack_d;
  logic clamped_q, clamped_d;
  logic busy_q, busy_d;
  logic clk_en_q, clk_en_d;
  logic dly_rst_q, dly_rst_d;
  logic dly_ce_q, dly_ce_d;
  logic dly_inc_q, dly_inc_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    cur_tap_d = cur_tap_q;
    ack_d     = ack_q;
    clamped_d = clamped_q;
    busy_d    = busy_q;
    clk_en_d  = clk_en_q;
    dly_rst_d = dly_rst_q;
    dly_ce_d  = dly_ce_q;
    dly_inc_d = dly_inc_q;
    req_tgt   = (target > MAX_T) ? MAX_T : target;

    unique case (state_q)
      // dly_rst_q doubles as the "RST pulse already issued" marker.
      S_INIT: begin
        if (!dly_rst_q) begin
          dly_rst_d = 1'b1;
        end else begin
          dly_rst_d = 1'b0;
          clk_en_d  = 1'b1;
          busy_d    = 1'b0;
          cur_tap_d = '0;
          state_d   = S_IDLE;
        end
      end
      S_IDLE: begin
        if (req) begin
          tgt_d     = req_tgt;
          clamped_d = (target > MAX_T);
          busy_d    = 1'b1;
          if (req_tgt == cur_tap_q) begin
            ack_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            clk_en_d  = 1'b0;
            dly_inc_d = (req_tgt > cur_tap_q);
            cnt_d     = GATE_LD;
            state_d   = S_GATE_OFF;
          end
        end
      end
      S_GATE_OFF: begin
        if (cnt_q == '0) begin
          dly_ce_d = 1'b1;
          state_d  = S_STEP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // Saturating step: the IODELAY wrap is never used.
      S_STEP: begin
        dly_ce_d = 1'b0;
        cnt_d    = SETL_LD;
        state_d  = S_SETTLE;
        if (dly_inc_q && cur_tap_q != MAX_T)
          cur_tap_d = cur_tap_q + 1'b1;
        else if (!dly_inc_q && cur_tap_q != '0)
          cur_tap_d = cur_tap_q - 1'b1;
      end
      S_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (cur_tap_q != tgt_q) begin
          dly_ce_d = 1'b1;
          state_d  = S_STEP;
        end else begin
          clk_en_d = 1'b1;
          cnt_d    = GATE_LD;
          state_d  = S_GATE_ON;
        end
      end
      S_GATE_ON: begin
        if (cnt_q == '0) begin
          ack_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      tgt_q     <= '0;
      cur_tap_q <= '0;
      ack_q     <= 1'b0;
      clamped_q <= 1'b0;
      busy_q    <= 1'b1;
      clk_en_q  <= 1'b0;
      dly_rst_q <= 1'b0;
      dly_ce_q  <= 1'b0;
      dly_inc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      cur_tap_q <= cur_tap_d;
      ack_q     <= ack_d;
      clamped_q <= clamped_d;
      busy_q    <= busy_d;
      clk_en_q  <= clk_en_d;
      dly_rst_q <= dly_rst_d;
      dly_ce_q  <= dly_ce_d;
      dly_inc_q <= dly_inc_d;
    end
  end

  assign ack     = ack_q;
  assign clamped = clamped_q;
  assign busy    = busy_q;
  assign cur_tap = cur_tap_q;
  assign clk_en  = clk_en_q;
  assign dly_rst = dly_rst_q;
  assign dly_ce  = dly_ce_q;
  assign dly_inc = dly_inc_q;

endmodule
